// File: rtl/img_processing_pkg.sv
// Shared image-processing types and constants: frame geometry defaults,
// AXI-Stream widths, the frame-capture state encoding and error-bit positions.
package img_processing_pkg;

  localparam int IMG_W            = 640;
  localparam int IMG_H            = 480;
  localparam int AXIS_TDATA_WIDTH = 8;
  localparam int AXIS_TUSER_WIDTH = 1;

  // Bit positions inside the sticky err_flags vector {sof_mid, long_line, short_line}
  localparam int ERR_SHORT_LINE = 0;
  localparam int ERR_LONG_LINE  = 1;
  localparam int ERR_SOF_MID    = 2;
  localparam int ERR_BITS       = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } capture_state_t;

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-Stream bundle used for pixel streams: tuser[0] marks
// start-of-frame and tlast marks end-of-line.
interface axi_stream_if #(
  parameter int DW = 8,
  parameter int UW = 1
) ();
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic [UW-1:0] tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/img_frame_ram.sv
// Simple dual-port frame buffer: one write port, one synchronous read port.
// A read and a write to the same address in one cycle returns the old word.
module img_frame_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Write and registered read share one edge, giving read-before-write behaviour
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/img_frame_capture.sv
// Captures one video frame from an AXI-Stream pixel source into a frame
// buffer on request, tracking line-length / restart errors and a checksum.
module img_frame_capture
  import img_processing_pkg::*;
#(
  parameter int TDATA_WIDTH = AXIS_TDATA_WIDTH,
  parameter int TUSER_WIDTH = AXIS_TUSER_WIDTH,
  parameter int FRAME_W     = IMG_W,
  parameter int FRAME_H     = IMG_H,
  localparam int DEPTH      = FRAME_W * FRAME_H,
  localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   arm,
  axi_stream_if.slave            s_axis,
  input  logic [AW-1:0]          rd_addr,
  output logic [TDATA_WIDTH-1:0] rd_data,
  output logic                   busy,
  output logic                   frame_done,
  output logic [ERR_BITS-1:0]    err_flags,
  output logic [15:0]            checksum,
  output logic [15:0]            frame_count
);

  capture_state_t state_q, state_d;
  logic                   tready_q, tready_d;
  logic [AW-1:0]          row_q, row_d;
  logic [AW-1:0]          col_q, col_d;
  logic [ERR_BITS-1:0]    err_q, err_d;
  logic [15:0]            sum_q, sum_d;
  logic [15:0]            count_q, count_d;
  logic                   done_q, done_d;

  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [AW-1:0]          lin_addr;
  logic [TDATA_WIDTH-1:0] pix;
  logic [TUSER_WIDTH-1:0] user;
  logic                   sof;
  logic                   accept;
  logic                   last_col;
  logic                   last_row;
  logic                   end_of_row;

  assign pix        = s_axis.tdata;
  assign user       = s_axis.tuser;
  assign sof        = user[0];
  assign accept     = s_axis.tvalid && tready_q;
  assign last_col   = (col_q == AW'(FRAME_W - 1));
  assign last_row   = (row_q == AW'(FRAME_H - 1));
  assign end_of_row = s_axis.tlast || last_col;
  assign lin_addr   = AW'(row_q * AW'(FRAME_W)) + col_q;

  // Next-state, counter, error and write-port logic for the capture FSM
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    err_d   = err_q;
    sum_d   = sum_q;
    count_d = count_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = lin_addr;

    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d = WAIT_SOF;
          err_d   = '0;
          sum_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      WAIT_SOF: begin
        if (accept && sof) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          sum_d   = 16'(pix);
          row_d   = '0;
          col_d   = AW'(1);
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (accept) begin
          wr_en = 1'b1;
          if (sof) begin
            err_d[ERR_SOF_MID] = 1'b1;
            wr_addr = '0;
            sum_d   = 16'(pix);
            row_d   = '0;
            col_d   = AW'(1);
          end else begin
            sum_d = sum_q + 16'(pix);
            if (s_axis.tlast && !last_col) begin
              err_d[ERR_SHORT_LINE] = 1'b1;
            end
            if (!s_axis.tlast && last_col) begin
              err_d[ERR_LONG_LINE] = 1'b1;
            end
            if (end_of_row) begin
              col_d = '0;
              if (last_row) begin
                done_d  = 1'b1;
                count_d = count_q + 16'd1;
                state_d = DONE;
              end else begin
                row_d = row_q + AW'(1);
              end
            end else begin
              col_d = col_q + AW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tready_d = (state_d == WAIT_SOF) || (state_d == CAPTURE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      tready_q <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      err_q    <= '0;
      sum_q    <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tready_q <= tready_d;
      row_q    <= row_d;
      col_q    <= col_d;
      err_q    <= err_d;
      sum_q    <= sum_d;
      count_q  <= count_d;
      done_q   <= done_d;
    end
  end

  assign s_axis.tready = tready_q;
  assign busy          = (state_q == WAIT_SOF) || (state_q == CAPTURE);
  assign frame_done    = done_q;
  assign err_flags     = err_q;
  assign checksum      = sum_q;
  assign frame_count   = count_q;

  img_frame_ram #(
    .DW    (TDATA_WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (pix),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_img_frame_capture.sv
// Directed bench for img_frame_capture on a 4x3 frame: clean capture, SOF
// hunting, short/long lines, mid-frame restart and reset during capture.
module tb_img_frame_capture;
  import img_processing_pkg::*;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          arm = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          busy;
  logic          frame_done;
  logic [2:0]    err_flags;
  logic [15:0]   checksum;
  logic [15:0]   frame_count;

  int checks = 0;
  int errors = 0;
  int doneCount = 0;
  int doneBefore;
  bit randomGaps = 1'b0;

  logic [7:0]  expMem [N];
  logic [31:0] readQ [$];

  axi_stream_if #(.DW(8), .UW(1)) axis ();

  img_frame_capture #(
    .TDATA_WIDTH (8),
    .TUSER_WIDTH (1),
    .FRAME_W     (W),
    .FRAME_H     (H)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .arm         (arm),
    .s_axis      (axis),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_flags   (err_flags),
    .checksum    (checksum),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  // Count frame_done pulses, sampled away from the active edge
  always @(negedge clk) begin
    if (frame_done === 1'b1) doneCount++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseArm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Drive one beat and hold it until accepted; addr < 0 means the beat is discarded
  task automatic applyStimulus(input logic [7:0] d, input logic sof, input logic last, input int addr);
    int waited;
    if (randomGaps) begin
      axis.tvalid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    axis.tdata  = d;
    axis.tuser  = sof;
    axis.tlast  = last;
    axis.tvalid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (axis.tready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) begin
      checkOutput("beat_accept_timeout", 32'(axis.tready), 32'd1);
    end else begin
      @(posedge clk);
      #1;
      if (addr >= 0) expMem[addr] = d;
    end
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    axis.tuser  = 1'b0;
  endtask

  task automatic sendCleanFrame(input int base);
    for (int i = 0; i < N; i++) begin
      applyStimulus(8'(base + i), (i == 0), ((i % W) == W - 1), i);
    end
  endtask

  // Read every location through the scoreboard queue and compare the registered data
  task automatic readBack(input string name);
    for (int a = 0; a < N; a++) begin
      rd_addr = AW'(a);
      readQ.push_back(32'(expMem[a]));
      tick();
      checkOutput($sformatf("%s_rd%0d", name, a), 32'(rd_data), readQ.pop_front());
    end
  endtask

  initial begin
    axis.tdata  = '0;
    axis.tuser  = '0;
    axis.tlast  = 1'b0;
    axis.tvalid = 1'b0;
    repeat (3) tick();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_tready", 32'(axis.tready), 32'd0);
    checkOutput("rst_done", 32'(frame_done), 32'd0);
    checkOutput("rst_err", 32'(err_flags), 32'd0);
    checkOutput("rst_checksum", 32'(checksum), 32'd0);
    checkOutput("rst_count", 32'(frame_count), 32'd0);
    resetn = 1'b1;
    tick();

    $display("[TB] clean frame");
    pulseArm();
    checkOutput("arm_busy", 32'(busy), 32'd1);
    checkOutput("arm_tready", 32'(axis.tready), 32'd1);
    sendCleanFrame(1);
    checkOutput("a_done_pulse", 32'(frame_done), 32'd1);
    tick();
    checkOutput("a_done_width", 32'(frame_done), 32'd0);
    checkOutput("a_tready_drop", 32'(axis.tready), 32'd0);
    tick();
    checkOutput("a_done_count", 32'(doneCount), 32'd1);
    checkOutput("a_checksum", 32'(checksum), 32'd78);
    checkOutput("a_err", 32'(err_flags), 32'd0);
    checkOutput("a_frame_count", 32'(frame_count), 32'd1);
    checkOutput("a_busy", 32'(busy), 32'd0);
    readBack("a");

    $display("[TB] beats before SOF are discarded");
    pulseArm();
    checkOutput("b_checksum_clr", 32'(checksum), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(8'(8'hA0 + i), 1'b0, (i == 2), -1);
    checkOutput("b_wait_busy", 32'(busy), 32'd1);
    rd_addr = '0;
    readQ.push_back(32'(expMem[0]));
    applyStimulus(8'd21, 1'b1, 1'b0, 0);
    checkOutput("b_rd_during_wr", 32'(rd_data), readQ.pop_front());
    for (int i = 1; i < N; i++) applyStimulus(8'(21 + i), 1'b0, ((i % W) == W - 1), i);
    repeat (2) tick();
    checkOutput("b_checksum", 32'(checksum), 32'd318);
    checkOutput("b_err", 32'(err_flags), 32'd0);
    checkOutput("b_frame_count", 32'(frame_count), 32'd2);
    readBack("b");

    $display("[TB] short first line");
    pulseArm();
    doneBefore = doneCount;
    applyStimulus(8'd41, 1'b1, 1'b0, 0);
    applyStimulus(8'd42, 1'b0, 1'b0, 1);
    applyStimulus(8'd43, 1'b0, 1'b1, 2);
    for (int i = 0; i < 7; i++) applyStimulus(8'(44 + i), 1'b0, (i == 3), 4 + i);
    tick();
    checkOutput("c_no_early_done", 32'(doneCount), 32'(doneBefore));
    applyStimulus(8'd51, 1'b0, 1'b1, 11);
    repeat (2) tick();
    checkOutput("c_done_count", 32'(doneCount), 32'(doneBefore + 1));
    checkOutput("c_err", 32'(err_flags), 32'b001);
    checkOutput("c_checksum", 32'(checksum), 32'd506);
    readBack("c");

    $display("[TB] long second line");
    pulseArm();
    doneBefore = doneCount;
    for (int i = 0; i < N; i++) applyStimulus(8'(61 + i), (i == 0), (i == 3 || i == 11), i);
    repeat (2) tick();
    checkOutput("d_done_count", 32'(doneCount), 32'(doneBefore + 1));
    checkOutput("d_err", 32'(err_flags), 32'b010);
    checkOutput("d_checksum", 32'(checksum), 32'd798);
    readBack("d");

    $display("[TB] SOF in the middle of a frame");
    pulseArm();
    doneBefore = doneCount;
    for (int i = 0; i < 5; i++) applyStimulus(8'(81 + i), (i == 0), (i == 3), i);
    applyStimulus(8'd86, 1'b1, 1'b0, 0);
    pulseArm();
    checkOutput("e_arm_ignored", 32'(err_flags), 32'b100);
    for (int i = 1; i < N; i++) applyStimulus(8'(86 + i), 1'b0, ((i % W) == W - 1), i);
    repeat (2) tick();
    checkOutput("e_done_count", 32'(doneCount), 32'(doneBefore + 1));
    checkOutput("e_err", 32'(err_flags), 32'b100);
    checkOutput("e_checksum", 32'(checksum), 32'd1098);
    checkOutput("e_frame_count", 32'(frame_count), 32'd5);
    readBack("e");

    $display("[TB] reset mid-frame with random tvalid");
    randomGaps = 1'b1;
    pulseArm();
    doneBefore = doneCount;
    for (int i = 0; i < 5; i++) applyStimulus(8'(201 + i), (i == 0), (i == 3), i);
    resetn = 1'b0;
    tick();
    checkOutput("f_rst_busy", 32'(busy), 32'd0);
    checkOutput("f_rst_tready", 32'(axis.tready), 32'd0);
    checkOutput("f_rst_count", 32'(frame_count), 32'd0);
    checkOutput("f_rst_checksum", 32'(checksum), 32'd0);
    tick();
    resetn = 1'b1;
    repeat (2) tick();
    checkOutput("f_no_partial_done", 32'(doneCount), 32'(doneBefore));
    checkOutput("f_idle_busy", 32'(busy), 32'd0);
    pulseArm();
    sendCleanFrame(101);
    repeat (2) tick();
    checkOutput("f_done_count", 32'(doneCount), 32'(doneBefore + 1));
    checkOutput("f_frame_count", 32'(frame_count), 32'd1);
    checkOutput("f_checksum", 32'(checksum), 32'd1278);
    checkOutput("f_err", 32'(err_flags), 32'd0);
    readBack("f");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
